lock_on_reset: RTL and testbench

LOCK_ON_RESET -- requirements
Module: lock_on_reset

---
 rtl/lock_on_reset.sv | 23 ++
 tb/tb_lock_on_reset.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lock_on_reset.sv
// Write-protected register: loads d only while unlock is high and holds otherwise.
// An asynchronous active-low reset forces the stored value back to RESET_VALUE.
module lock_on_reset #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             unlock,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] locked
);

  // unlock is a level sampled with d at the same edge; the data flop is the only state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      locked <= RESET_VALUE;
    end else if (unlock) begin
      locked <= d;
    end
  end

endmodule

// File: tb/tb_lock_on_reset.sv
// Directed bench for lock_on_reset: stimulus on falling edges, locked checked
// 1 ns after each rising edge and right after asynchronous reset assertion.
module tb_lock_on_reset;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic       unlock = 1'b0;
  logic [0:0] d      = 1'b0;
  logic [0:0] locked;

  int total = 0;
  int bad   = 0;

  lock_on_reset dut (
    .clk    (clk),
    .resetn (resetn),
    .unlock (unlock),
    .d      (d),
    .locked (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [0:0] exp);
    total++;
    assert (locked === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, locked, exp);
    end
  endtask

  task automatic step_check(input string tag, input logic [0:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    // Reset with write enabled and d=1: must clear immediately and stay cleared
    unlock = 1'b1;
    d      = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_async", 1'b0);
    step_check("reset_hold_edge1", 1'b0);
    @(negedge clk);
    unlock = 1'b0;
    d      = 1'b1;
    step_check("reset_hold_edge2", 1'b0);

    // Unlocked writes
    @(negedge clk);
    resetn = 1'b1;
    unlock = 1'b1;
    d      = 1'b1;
    step_check("write_1", 1'b1);
    @(negedge clk);
    d = 1'b0;
    step_check("write_0", 1'b0);

    // Locked hold at 0 with d=1 for two cycles
    @(negedge clk);
    unlock = 1'b0;
    d      = 1'b1;
    step_check("hold0_c1", 1'b0);
    @(negedge clk);
    d = 1'b1;
    step_check("hold0_c2", 1'b0);

    // Reset clears a stored 1, then stays 0 while locked
    @(negedge clk);
    unlock = 1'b1;
    d      = 1'b1;
    step_check("pre_reset_write1", 1'b1);
    @(negedge clk);
    unlock = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_clears_async", 1'b0);
    step_check("reset_clears_edge", 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    unlock = 1'b0;
    d      = 1'b1;
    step_check("post_reset_locked_c1", 1'b0);
    @(negedge clk);
    d = 1'b0;
    step_check("post_reset_locked_c2", 1'b0);

    // Locked hold at 1 while d toggles, then reset
    @(negedge clk);
    unlock = 1'b1;
    d      = 1'b1;
    step_check("hold1_write", 1'b1);
    @(negedge clk);
    unlock = 1'b0;
    d      = 1'b0;
    step_check("hold1_c1", 1'b1);
    @(negedge clk);
    d = 1'b0;
    step_check("hold1_c2", 1'b1);
    @(negedge clk);
    d = 1'b1;
    step_check("hold1_toggle_c3", 1'b1);
    @(negedge clk);
    d = 1'b0;
    step_check("hold1_toggle_c4", 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("hold1_reset_async", 1'b0);

    // Simultaneous unlock 1->0 with d 1->0: prior value 1 is kept
    @(negedge clk);
    resetn = 1'b1;
    unlock = 1'b1;
    d      = 1'b1;
    step_check("simul_setup", 1'b1);
    @(negedge clk);
    unlock = 1'b0;
    d      = 1'b0;
    step_check("simul_fall_ignored", 1'b1);
    step_check("simul_fall_hold", 1'b1);

    // Unlock rising together with new d: loaded at that edge
    @(negedge clk);
    unlock = 1'b1;
    d      = 1'b0;
    step_check("simul_rise_loaded", 1'b0);

    // Reset mid-operation, then a normal unlocked write
    @(negedge clk);
    unlock = 1'b1;
    d      = 1'b1;
    step_check("mid_write1", 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_reset_async", 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    unlock = 1'b1;
    d      = 1'b1;
    step_check("write_after_reset", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
